// File: rtl/sd_cmd_issuer.sv
// Bus initiator that pushes one SD command (index + argument) into the SD controller's
// TX command FIFO, then optionally polls status/timer and gathers response bytes.
module sd_cmd_issuer #(
    parameter int RESP_BYTES = 6,
    parameter int CMD_BYTES  = 5
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    start_i,
    input  logic [5:0]              cmd_idx_i,
    input  logic [31:0]             cmd_arg_i,
    input  logic                    resp_en_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic [8*RESP_BYTES-1:0] resp_o,
    output logic [2:0]              av_address,
    output logic [7:0]              av_writedata,
    input  logic [7:0]              av_readdata,
    output logic                    av_write_n,
    output logic                    av_read_n,
    output logic                    av_chipselect,
    input  logic                    av_waitrequest
);

    localparam int         RW        = 8 * RESP_BYTES;
    localparam logic [4:0] CMD_LAST  = 5'(CMD_BYTES);
    localparam logic [4:0] RESP_LAST = 5'(RESP_BYTES);
    localparam logic [2:0] A_TX      = 3'd0;
    localparam logic [2:0] A_RX      = 3'd1;
    localparam logic [2:0] A_STAT    = 3'd4;
    localparam logic [2:0] A_TMR     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_STAT,
        S_WR_BYTE,
        S_RD_STAT,
        S_RD_TIMER,
        S_RD_BYTE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [39:0]     cmd_q, cmd_d;
    logic            resp_en_q, resp_en_d;
    logic            tout_q, tout_d;
    logic [RW-1:0]   resp_q, resp_d;
    logic            act_q, act_d;
    logic            gap_q, gap_d;
    logic            cs_q, cs_d;
    logic            wr_n_q, wr_n_d;
    logic            rd_n_q, rd_n_d;
    logic [2:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;

    logic [4:0]      cnt_inc;
    logic [2:0]      acc_addr;
    logic            acc_wr;

    assign cnt_inc = cnt_q + 5'd1;

    always_comb begin
        acc_addr = A_STAT;
        acc_wr   = 1'b0;
        case (state_q)
            S_WR_BYTE: begin
                acc_addr = A_TX;
                acc_wr   = 1'b1;
            end
            S_RD_BYTE:  acc_addr = A_RX;
            S_RD_TIMER: acc_addr = A_TMR;
            default:    acc_addr = A_STAT;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        resp_en_d = resp_en_q;
        tout_d    = tout_q;
        resp_d    = resp_q;
        act_d     = act_q;
        gap_d     = gap_q;
        cs_d      = cs_q;
        wr_n_d    = wr_n_q;
        rd_n_d    = rd_n_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cmd_d     = {2'b01, cmd_idx_i, cmd_arg_i};
                    resp_en_d = resp_en_i;
                    resp_d    = '0;
                    cnt_d     = 5'd0;
                    tout_d    = 1'b0;
                    gap_d     = 1'b0;
                    state_d   = S_WR_STAT;
                end
            end
            S_DONE: begin
                tout_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                // Every access: assert, hold until waitrequest drops, then one idle cycle.
                if (!act_q) begin
                    if (gap_q) begin
                        gap_d = 1'b0;
                    end else begin
                        act_d  = 1'b1;
                        cs_d   = 1'b1;
                        addr_d = acc_addr;
                        if (acc_wr) begin
                            wr_n_d  = 1'b0;
                            wdata_d = cmd_q[39:32];
                        end else begin
                            rd_n_d = 1'b0;
                        end
                    end
                end else if (!av_waitrequest) begin
                    act_d  = 1'b0;
                    cs_d   = 1'b0;
                    wr_n_d = 1'b1;
                    rd_n_d = 1'b1;
                    gap_d  = 1'b1;
                    case (state_q)
                        S_WR_STAT: begin
                            if (!av_readdata[0]) begin
                                state_d = S_WR_BYTE;
                            end
                        end
                        S_WR_BYTE: begin
                            cmd_d = cmd_q << 8;
                            cnt_d = cnt_inc;
                            if (cnt_inc != CMD_LAST) begin
                                state_d = S_WR_STAT;
                            end else if (resp_en_q) begin
                                cnt_d   = 5'd0;
                                state_d = S_RD_STAT;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        S_RD_STAT: begin
                            state_d = av_readdata[1] ? S_RD_TIMER : S_RD_BYTE;
                        end
                        S_RD_TIMER: begin
                            if (av_readdata == 8'd0) begin
                                tout_d  = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_RD_STAT;
                            end
                        end
                        S_RD_BYTE: begin
                            resp_d  = (resp_q << 8) | RW'(av_readdata);
                            cnt_d   = cnt_inc;
                            state_d = (cnt_inc == RESP_LAST) ? S_DONE : S_RD_STAT;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            cmd_q     <= '0;
            resp_en_q <= 1'b0;
            tout_q    <= 1'b0;
            resp_q    <= '0;
            act_q     <= 1'b0;
            gap_q     <= 1'b0;
            cs_q      <= 1'b0;
            wr_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            addr_q    <= 3'd0;
            wdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            resp_en_q <= resp_en_d;
            tout_q    <= tout_d;
            resp_q    <= resp_d;
            act_q     <= act_d;
            gap_q     <= gap_d;
            cs_q      <= cs_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = (state_q == S_DONE);
    assign timeout_o     = (state_q == S_DONE) && tout_q;
    assign resp_o        = resp_q;
    assign av_address    = addr_q;
    assign av_writedata  = wdata_q;
    assign av_write_n    = wr_n_q;
    assign av_read_n     = rd_n_q;
    assign av_chipselect = cs_q;

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// Randomized scoreboard bench for sd_cmd_issuer: a scripted slave model plus a
// reference model that derives the expected bus accesses and final response.
module tb_sd_cmd_issuer;

    localparam int RB = 6;
    localparam int RW = 8 * RB;

    logic          wb_clk_i;
    logic          wb_rst_n_i;
    logic          start_i;
    logic [5:0]    cmd_idx_i;
    logic [31:0]   cmd_arg_i;
    logic          resp_en_i;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;
    logic [RW-1:0] resp_o;
    logic [2:0]    av_address;
    logic [7:0]    av_writedata;
    logic [7:0]    av_readdata;
    logic          av_write_n;
    logic          av_read_n;
    logic          av_chipselect;
    logic          av_waitrequest;

    sd_cmd_issuer #(.RESP_BYTES(RB), .CMD_BYTES(5)) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_n_i     (wb_rst_n_i),
        .start_i        (start_i),
        .cmd_idx_i      (cmd_idx_i),
        .cmd_arg_i      (cmd_arg_i),
        .resp_en_i      (resp_en_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o),
        .resp_o         (resp_o),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_write_n     (av_write_n),
        .av_read_n      (av_read_n),
        .av_chipselect  (av_chipselect),
        .av_waitrequest (av_waitrequest)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int checks;
    int failures;
    int seq_no;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scripted slave: per-register response streams written by the planner,
    // consumed by the slave on each completed read.
    logic [7:0] stat_arr [8192];
    logic [7:0] tmr_arr  [8192];
    logic [7:0] rx_arr   [8192];
    int stat_wr, tmr_wr, rx_wr;
    int stat_rd, tmr_rd, rx_rd;
    int wait_cnt, wait_tgt, wait_max;
    int wr_count, stall_wr_idx;
    int eff_tgt;
    logic rd_act, wr_act;

    assign rd_act = av_chipselect && !av_read_n;
    assign wr_act = av_chipselect && !av_write_n;
    assign eff_tgt = (wr_act && wr_count == stall_wr_idx) ? 4 : wait_tgt;
    assign av_waitrequest = (rd_act || wr_act) && (wait_cnt < eff_tgt);
    assign av_readdata = !rd_act ? 8'h00 :
                         (av_address == 3'd4) ? stat_arr[stat_rd] :
                         (av_address == 3'd6) ? tmr_arr[tmr_rd] :
                         (av_address == 3'd1) ? rx_arr[rx_rd] : 8'h00;

    always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            stat_rd  <= stat_wr;
            tmr_rd   <= tmr_wr;
            rx_rd    <= rx_wr;
            wait_cnt <= 0;
            wait_tgt <= 0;
        end else if (rd_act || wr_act) begin
            if (av_waitrequest) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
                wait_tgt <= $urandom_range(wait_max, 0);
                if (wr_act) wr_count <= wr_count + 1;
                else if (av_address == 3'd4) stat_rd <= stat_rd + 1;
                else if (av_address == 3'd6) tmr_rd <= tmr_rd + 1;
                else if (av_address == 3'd1) rx_rd <= rx_rd + 1;
            end
        end
    end

    typedef struct packed {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
    } acc_t;

    typedef struct packed {
        logic          tout;
        logic [RW-1:0] resp;
    } done_t;

    acc_t  exp_q  [$];
    done_t done_q [$];

    // Planner knobs
    int k_full_min, k_full_max, k_full_byte, k_full_n;
    int k_empty_min, k_empty_max, k_navail;
    bit k_rx_fixed;
    logic [RW-1:0] k_rx_val;

    function automatic void push_stat(input logic [7:0] v);
        stat_arr[stat_wr] = v;
        stat_wr++;
    endfunction

    function automatic void push_acc(input logic wr, input logic [2:0] addr, input logic [7:0] data);
        acc_t a;
        a.wr = wr; a.addr = addr; a.data = data;
        exp_q.push_back(a);
    endfunction

    // Reference model: walks the command/response protocol byte by byte,
    // choosing slave behaviour and recording what the initiator must do.
    task automatic plan_seq(input logic [5:0] idx, input logic [31:0] arg, input bit ren);
        logic [7:0]    b [5];
        logic [7:0]    r8;
        logic [RW-1:0] resp;
        done_t         d;
        int            nf, ne;
        bit            tout;
        b[0] = {2'b01, idx};
        b[1] = arg[31:24];
        b[2] = arg[23:16];
        b[3] = arg[15:8];
        b[4] = arg[7:0];
        for (int i = 0; i < 5; i++) begin
            nf = (i == k_full_byte) ? k_full_n : $urandom_range(k_full_max, k_full_min);
            for (int f = 0; f < nf; f++) begin
                r8 = 8'($urandom);
                push_stat({r8[7:1], 1'b1});
                push_acc(1'b0, 3'd4, 8'h00);
            end
            r8 = 8'($urandom);
            push_stat({r8[7:1], 1'b0});
            push_acc(1'b0, 3'd4, 8'h00);
            push_acc(1'b1, 3'd0, b[i]);
        end
        resp = '0;
        tout = 1'b0;
        if (ren) begin
            for (int i = 0; i < RB; i++) begin
                ne = $urandom_range(k_empty_max, k_empty_min);
                for (int j = 0; j < ne; j++) begin
                    r8 = 8'($urandom);
                    push_stat({r8[7:2], 1'b1, r8[0]});
                    push_acc(1'b0, 3'd4, 8'h00);
                    tmr_arr[tmr_wr] = (i < k_navail) ? 8'($urandom_range(255, 1)) : 8'(ne - j + 1);
                    tmr_wr++;
                    push_acc(1'b0, 3'd6, 8'h00);
                end
                r8 = 8'($urandom);
                if (i < k_navail) begin
                    push_stat({r8[7:2], 1'b0, r8[0]});
                    push_acc(1'b0, 3'd4, 8'h00);
                    r8 = k_rx_fixed ? k_rx_val[RW-1-8*i -: 8] : 8'($urandom);
                    rx_arr[rx_wr] = r8;
                    rx_wr++;
                    push_acc(1'b0, 3'd1, 8'h00);
                    resp = (resp << 8) | RW'(r8);
                end else begin
                    push_stat({r8[7:2], 1'b1, r8[0]});
                    push_acc(1'b0, 3'd4, 8'h00);
                    tmr_arr[tmr_wr] = 8'h00;
                    tmr_wr++;
                    push_acc(1'b0, 3'd6, 8'h00);
                    tout = 1'b1;
                    break;
                end
            end
        end
        d.tout = tout;
        d.resp = resp;
        done_q.push_back(d);
    endtask

    // Monitor: bus-rule checks every cycle, scoreboard pop on every completion and done.
    int   done_seen;
    logic prev_stall, prev_cmp, mon_act;
    logic [13:0] prev_bus;
    acc_t  mon_a;
    done_t mon_d;

    always @(negedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            prev_stall = 1'b0;
            prev_cmp   = 1'b0;
        end else begin
            mon_act = av_chipselect && (!av_read_n || !av_write_n);
            if (av_chipselect) chk("one_strobe", 64'(av_read_n ^ av_write_n), 64'd1);
            else               chk("idle_strobes", {av_read_n, av_write_n}, 64'd3);
            if (prev_stall)
                chk("stall_stable", {av_address, av_writedata, av_read_n, av_write_n, av_chipselect}, 64'(prev_bus));
            if (prev_cmp) chk("idle_gap", 64'(av_chipselect), 64'd0);
            if (mon_act && !av_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_access actual=wr%0d@%0d required=none t=%0t", !av_write_n, av_address, $time);
                end else begin
                    mon_a = exp_q.pop_front();
                    chk("acc_kind", {!av_write_n, av_address}, {mon_a.wr, mon_a.addr});
                    if (mon_a.wr) chk("wr_data", 64'(av_writedata), 64'(mon_a.data));
                end
            end
            prev_stall = mon_act && av_waitrequest;
            prev_cmp   = mon_act && !av_waitrequest;
            prev_bus   = {av_address, av_writedata, av_read_n, av_write_n, av_chipselect};
            if (done_o) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("timeout", 64'(timeout_o), 64'(mon_d.tout));
                    chk("resp", 64'(resp_o), 64'(mon_d.resp));
                    chk("busy_at_done", 64'(busy_o), 64'd0);
                end
                done_seen++;
            end else if (timeout_o) begin
                chk("timeout_without_done", 64'(timeout_o), 64'd0);
            end
        end
    end

    task automatic run_seq(input logic [5:0] idx, input logic [31:0] arg, input bit ren, input bit spur);
        int n0;
        bit got;
        plan_seq(idx, arg, ren);
        $display("seq %0d idx=%02h arg=%08h resp_en=%0d", seq_no, idx, arg, ren);
        seq_no++;
        @(negedge wb_clk_i);
        cmd_idx_i = idx;
        cmd_arg_i = arg;
        resp_en_i = ren;
        start_i   = 1'b1;
        n0        = done_seen;
        @(negedge wb_clk_i);
        start_i   = 1'b0;
        cmd_idx_i = 6'($urandom);
        cmd_arg_i = $urandom;
        resp_en_i = 1'($urandom);
        got = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done_seen != n0) begin
                got = 1'b1;
                break;
            end
            start_i = (spur && busy_o && $urandom_range(7, 0) == 0);
            @(negedge wb_clk_i);
        end
        start_i = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done seq=%0d", seq_no - 1);
        end
        repeat (2) @(negedge wb_clk_i);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic set_defaults();
        k_full_min = 0; k_full_max = 0; k_full_byte = -1; k_full_n = 0;
        k_empty_min = 0; k_empty_max = 0; k_navail = RB;
        k_rx_fixed = 1'b0; k_rx_val = '0;
        wait_max = 0; stall_wr_idx = -1;
    endtask

    initial begin
        bit seen;
        checks = 0; failures = 0; seq_no = 0; done_seen = 0;
        stat_wr = 0; tmr_wr = 0; rx_wr = 0; wr_count = 0;
        start_i = 1'b0; cmd_idx_i = '0; cmd_arg_i = '0; resp_en_i = 1'b0;
        set_defaults();
        wb_rst_n_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        chk("rst_resp", 64'(resp_o), 64'd0);
        chk("rst_bus", {av_chipselect, av_write_n, av_read_n, av_address, av_writedata}, {1'b0, 1'b1, 1'b1, 3'd0, 8'd0});
        wb_rst_n_i = 1'b1;

        // Zero-wait slave, write-only command
        run_seq(6'h11, 32'h0000_0200, 1'b0, 1'b0);
        // TX FIFO full for three polls before the second write
        k_full_byte = 1; k_full_n = 3;
        run_seq(6'h11, 32'h0000_0200, 1'b0, 1'b0);
        set_defaults();
        // Full response collection with fixed bytes
        k_rx_fixed = 1'b1; k_rx_val = 48'h11_0000_0900FF;
        run_seq(6'h08, 32'h0000_01AA, 1'b1, 1'b0);
        set_defaults();
        // Response timeout: timers 3, 2, then 0
        k_navail = 0; k_empty_min = 2; k_empty_max = 2;
        run_seq(6'h37, 32'hDEAD_BEEF, 1'b1, 1'b0);
        set_defaults();
        // Four-cycle stall on the first write
        stall_wr_idx = wr_count;
        run_seq(6'h2A, 32'h1234_5678, 1'b0, 1'b0);
        set_defaults();

        // Reset in the middle of a response byte read
        plan_seq(6'h02, 32'h0, 1'b1);
        $display("seq %0d reset-abort during RD_BYTE", seq_no);
        seq_no++;
        @(negedge wb_clk_i);
        cmd_idx_i = 6'h02; cmd_arg_i = 32'h0; resp_en_i = 1'b1; start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (av_chipselect && !av_read_n && av_address == 3'd1) begin
                seen = 1'b1;
                break;
            end
            @(negedge wb_clk_i);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL rd_byte_wait actual=not_reached required=rd_byte");
        end
        #2 wb_rst_n_i = 1'b0;
        #1;
        chk("abort_bus", {av_chipselect, av_write_n, av_read_n, av_address, av_writedata}, {1'b0, 1'b1, 1'b1, 3'd0, 8'd0});
        chk("abort_status", {busy_o, done_o, timeout_o}, 64'd0);
        chk("abort_resp", 64'(resp_o), 64'd0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        run_seq(6'h0D, 32'hCAFE_0001, 1'b1, 1'b0);

        // Randomized sequences
        for (int s = 0; s < 25; s++) begin
            set_defaults();
            k_full_max  = $urandom_range(2, 0);
            k_empty_max = $urandom_range(2, 0);
            k_navail    = ($urandom_range(3, 0) == 0) ? $urandom_range(RB - 1, 0) : RB;
            wait_max    = $urandom_range(2, 0);
            run_seq(6'($urandom), $urandom, 1'($urandom), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
